// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
        logic            exc_adel;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer holding the instruction word acked while ID was stalled.
module fetch_skid_buf #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (clear_i) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack fetch, skid buffer and IF/ID register.
// Optional misaligned-PC detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        id_stall,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pc_en,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        id_exc_adel
);

    localparam int unsigned BUF_W = XLEN + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;
    logic [XLEN-1:0]  id_pc8_q, id_pc8_d;

    logic             misaligned;
    logic             fetch_done;
    logic             advance;
    logic             buf_load;
    logic             buf_clear;
    logic [XLEN-1:0]  fetch_word;
    logic [BUF_W-1:0] buf_dout;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned fetch completes locally as if acked with a zero word
    assign im_req     = reset_n && (state_q == FETCH) && !misaligned;
    assign fetch_done = (im_req && im_ack) || (reset_n && (state_q == FETCH) && misaligned);
    assign fetch_word = misaligned ? NOP : im_rdata;
    assign advance    = reset_n && !id_stall && (fetch_done || (state_q == HOLD));

    assign pc      = pc_q;
    assign pc4     = pc_q + 32'd4;
    assign pc_en   = advance;
    assign im_addr = {pc_q[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ifid_d    = ifid_q;
        id_pc8_d  = id_pc8_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (fetch_done) begin
                    if (!id_stall) begin
                        ifid_d   = '{instr: fetch_word, pc: pc_q, valid: 1'b1, exc_adel: misaligned};
                        id_pc8_d = pc_q + 32'd8;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (!id_stall) begin
                    // Memory wait: push a bubble, keep id_pc
                    ifid_d.instr    = NOP;
                    ifid_d.valid    = 1'b0;
                    ifid_d.exc_adel = 1'b0;
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    ifid_d    = '{instr: buf_dout[XLEN-1:0], pc: pc_q, valid: 1'b1,
                                  exc_adel: buf_dout[XLEN]};
                    id_pc8_d  = pc_q + 32'd8;
                    buf_clear = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (advance) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ifid_q   <= '0;
            id_pc8_q <= 32'd8;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            id_pc8_q <= id_pc8_d;
        end
    end

    fetch_skid_buf #(
        .W (BUF_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  ({misaligned, fetch_word}),
        .data_o  (buf_dout)
    );

    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc8      = id_pc8_q;
    assign id_valid    = ifid_q.valid;
    assign id_exc_adel = ifid_q.exc_adel;

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Sequential instruction-fetch stage of the five-stage MIPS pipeline. Holds the architectural PC and issues a req/ack fetch to instruction memory. Loads the fetched word into the IF/ID pipeline register. Consumes the next-PC value selected by the next-PC mux and drives that mux's hold enable, so stalls and slow memory both freeze the PC correctly. Branches are delayed, so no flush is required; the delay-slot instruction always enters IF/ID.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- next_pc  in  32  next-PC from next-PC mux, sampled only on an advance cycle
- id_stall  in  1  hazard unit: ID stage cannot accept a new instruction
- pc  out  32  current PC (fed back to next-PC mux PC input)
- pc4  out  32  pc + 4 (mux PC4 input)
- pc_en  out  1  advance strobe, drives next-PC mux en
- im_req  out  1  instruction-memory request
- im_addr  out  32  word-aligned fetch address {pc[31:2],2'b00}
- im_ack  in  1  memory response, valid only while im_req=1
- im_rdata  in  32  instruction word, valid when im_ack=1
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC
- id_pc8  out  32  id_pc + 8 (link value for jal/jalr)
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble, id_instr=0)
- id_exc_adel  out  1  IF/ID instruction fetched from a misaligned PC

## Operation
- States: FETCH (im_req=1, waiting ack) and HOLD (word buffered, waiting for ID to accept, im_req=0).
- FETCH, im_ack & !id_stall: IF/ID <= {im_rdata, pc, valid=1}; pc <= next_pc; stay FETCH.
- FETCH, im_ack & id_stall: skid buffer <= im_rdata; IF/ID unchanged; PC unchanged; go HOLD.
- FETCH, !im_ack & !id_stall: IF/ID <= bubble (instr 0, valid 0, id_pc unchanged); PC unchanged.
- FETCH, !im_ack & id_stall: everything holds.
- HOLD, !id_stall: IF/ID <= {buffer, pc, valid=1}; pc <= next_pc; go FETCH. HOLD, id_stall: hold.
- pc_en = advance = (FETCH & im_ack & !id_stall) | (HOLD & !id_stall). The PC register loads only when advance=1.
- Address arithmetic: pc4, id_pc8 are modulo 2^32. 32'hFFFF_FFFC + 4 = 0.
- Memory protocol: once raised, im_req and im_addr stay constant until the ack cycle. At most one request is outstanding. An ack arriving while im_req=0 is ignored.

## Timing
- Reset (reset_n=0 at posedge): pc=RESET_PC, state FETCH, id_instr=0, id_pc=0, id_valid=0, id_exc_adel=0, buffer=0.
- While reset_n=0, im_req=0 and pc_en=0. im_req=1 in the first cycle after release.
- Reset asserted mid-request or in HOLD: the outstanding request is abandoned and the buffer is discarded. The memory must tolerate a dropped req.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. Latency from pc to id_instr is 1 clock.
- N wait cycles: N bubbles into ID when ID is not stalled.
- im_req, pc_en, im_addr, pc, pc4 are combinational from state/pc/inputs. All id_* outputs are registered.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - In FETCH with pc[1:0]!=0: im_req=0.
  - The stage acts as if acked with word 0 and sets id_exc_adel=1 on that IF/ID entry.
  - Normal advance rules apply, including HOLD if stalled.
- FETCH_ALIGN_CHECK_EN undefined: pc[1:0] is ignored except that it is forwarded in id_pc. id_exc_adel is tied 0.

## Structure
- Package fetch_pkg:
  - RESET_PC default
  - state enum {FETCH, HOLD}
  - NOP constant 32'h0000_0000
  - IF/ID record typedef {instr, pc, valid, exc_adel}
- Sub-module fetch_skid_buf: one-entry buffer with load/hold/clear. It holds the word acked during a stall. Everything else lives in pc_fetch_stage.

## Test plan
- Reset then zero-wait memory, next_pc = pc4:
  - id_pc goes 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - id_valid=1 from cycle 2.
  - id_pc8 = 0x3008 when id_pc=0x3000.
- Memory with 2 wait cycles, no stall: two cycles of id_valid=0 between instructions. pc is held at 0x3004 until ack. im_addr is stable during the wait.
- Ack coincident with id_stall for 3 cycles:
  - State enters HOLD and im_req=0.
  - IF/ID keeps its previous word and pc_en=0 throughout.
  - On stall release, the buffered word appears with id_pc=0x3004, and pc becomes next_pc.
- Branch: next_pc=0x3100 presented when pc=0x3008 (delay slot). The delay slot at 0x3008 enters IF/ID, then the next fetch address is 0x3100.
- reset_n=0 while in HOLD: next cycle pc=0x3000, id_valid=0, state FETCH. The buffered word never appears.
- With FETCH_ALIGN_CHECK_EN, next_pc=0x3002: no im_req. The next IF/ID entry has id_exc_adel=1, id_instr=0, id_pc=0x3002.
